// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions for the reader (and later the encoder).
// Contents:
//   S0..S9, SBLANK : active-low segment patterns, bit6=a ... bit0=g
//   decode()       : pattern -> {legal, bcd[3:0]}; any non-digit pattern is illegal
//   state_e        : reader FSM states {COLLECT, HOLD}
package sseg_pkg;

    localparam logic [6:0] S0     = 7'b0000001;
    localparam logic [6:0] S1     = 7'b1001111;
    localparam logic [6:0] S2     = 7'b0010010;
    localparam logic [6:0] S3     = 7'b0000110;
    localparam logic [6:0] S4     = 7'b1001100;
    localparam logic [6:0] S5     = 7'b0100100;
    localparam logic [6:0] S6     = 7'b0100000;
    localparam logic [6:0] S7     = 7'b0001111;
    localparam logic [6:0] S8     = 7'b0000000;
    localparam logic [6:0] S9     = 7'b0000100;
    localparam logic [6:0] SBLANK = 7'b1111111;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

    // Returns {legal, bcd}. Illegal patterns (blank included) return all zeros.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            S0:      return {1'b1, 4'd0};
            S1:      return {1'b1, 4'd1};
            S2:      return {1'b1, 4'd2};
            S3:      return {1'b1, 4'd3};
            S4:      return {1'b1, 4'd4};
            S5:      return {1'b1, 4'd5};
            S6:      return {1'b1, 4'd6};
            S7:      return {1'b1, 4'd7};
            S8:      return {1'b1, 4'd8};
            S9:      return {1'b1, 4'd9};
            default: return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/sseg_reader_if.sv
// Bus between the seven-segment source / value consumer and sseg_reader.
// Signals:
//   seg_in[6:0]  segment pattern (active-low), digit_sel (0 ones, 1 tens),
//   seg_strobe   one-cycle qualifier for seg_in/digit_sel,
//   data_out[5:0], data_valid, data_ready : value handshake,
//   pattern_err, range_err                : one-cycle error pulses.
// Modports: master = stimulus/consumer side, slave = reader side.
interface sseg_reader_if;
    logic [6:0] seg_in;
    logic       digit_sel;
    logic       seg_strobe;
    logic [5:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       pattern_err;
    logic       range_err;

    modport master (
        output seg_in, digit_sel, seg_strobe, data_ready,
        input  data_out, data_valid, pattern_err, range_err
    );

    modport slave (
        input  seg_in, digit_sel, seg_strobe, data_ready,
        output data_out, data_valid, pattern_err, range_err
    );
endinterface

// File: rtl/sseg_digit_tracker.sv
// Stability tracker for one digit position.
// Holds the last legal pattern, a saturating match counter and a lock flag.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear            : synchronous clear back to the reset state (wins over update)
//   update           : a strobe addressed to this digit
//   legal, pattern   : decoded legality and raw pattern of the strobe
//   bcd_in           : decoded digit of the strobe
//   lock_upd/bcd_upd : lock and digit as they will be after this edge (ignoring
//                      clear), so the parent can complete a value in the same cycle
import sseg_pkg::*;

module sseg_digit_tracker #(
    parameter int STABLE_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       update,
    input  logic       legal,
    input  logic [6:0] pattern,
    input  logic [3:0] bcd_in,
    output logic       lock_upd,
    output logic [3:0] bcd_upd
);

    localparam int              CW     = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0]   TARGET = CW'(STABLE_COUNT);
    localparam logic [CW-1:0]   ONE    = CW'(1);

    logic [6:0]    pat_q,  pat_n;
    logic [3:0]    bcd_q,  bcd_n;
    logic [CW-1:0] cnt_q,  cnt_n;
    logic          lock_q, lock_n;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pat_n  = pat_q;
        bcd_n  = bcd_q;
        cnt_n  = cnt_q;
        lock_n = lock_q;
        if (update) begin
            if (!legal) begin
                pat_n  = SBLANK;
                bcd_n  = 4'd0;
                cnt_n  = '0;
                lock_n = 1'b0;
            end else if (pattern == pat_q) begin
                if (cnt_q != TARGET)
                    cnt_n = cnt_q + ONE;
                lock_n = (cnt_n == TARGET);
            end else begin
                // A new digit restarts the run; with STABLE_COUNT=1 it locks at once.
                pat_n  = pattern;
                bcd_n  = bcd_in;
                cnt_n  = ONE;
                lock_n = (ONE == TARGET);
            end
        end
    end

    assign lock_upd = lock_n;
    assign bcd_upd  = bcd_n;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pat_q  <= SBLANK;
            bcd_q  <= 4'd0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            pat_q  <= pat_n;
            bcd_q  <= bcd_n;
            cnt_q  <= cnt_n;
            lock_q <= lock_n;
        end
    end

endmodule

// File: rtl/sseg_reader.sv
// Seven-segment reader: decodes a strobed two-digit display bus back to a
// binary value (0..MAX_VALUE) and offers it on a valid/ready handshake.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : sseg_reader_if.slave (segment bus in, value handshake and error
//            pulses out)
import sseg_pkg::*;

module sseg_reader #(
    parameter int STABLE_COUNT = 4,
    parameter int MAX_VALUE    = 31
) (
    input  logic clk,
    input  logic reset,
    sseg_reader_if.slave bus
);

    localparam logic [0:0] ST_COLLECT = 1'(COLLECT);
    localparam logic [0:0] ST_HOLD    = 1'(HOLD);
    localparam logic [6:0] MAX_V      = 7'(MAX_VALUE);

    logic [0:0] state;
    logic [5:0] data_out_q;
    logic       data_valid_q;
    logic       pattern_err_q;
    logic       range_err_q;

    logic [4:0] dec;
    logic       legal;
    logic [3:0] bcd;
    logic       collecting;
    logic       upd_ones, upd_tens;
    logic       ones_lock, tens_lock;
    logic [3:0] ones_bcd, tens_bcd;
    logic [6:0] value;
    logic       complete;
    logic       in_range;
    logic       accept;
    logic       clear_trk;

    assign dec        = decode(bus.seg_in);
    assign legal      = dec[4];
    assign bcd        = dec[3:0];

    // Strobes only reach the trackers while collecting; in HOLD they are dropped.
    assign collecting = (state == ST_COLLECT);
    assign upd_ones   = collecting && bus.seg_strobe && !bus.digit_sel;
    assign upd_tens   = collecting && bus.seg_strobe &&  bus.digit_sel;

    // Combine from the trackers' post-edge view so the result registers on
    // the same edge as the completing strobe.
    assign value      = ({3'b000, tens_bcd} * 7'd10) + {3'b000, ones_bcd};
    assign complete   = collecting && ones_lock && tens_lock;
    assign in_range   = (value <= MAX_V);
    assign accept     = (state == ST_HOLD) && data_valid_q && bus.data_ready;
    assign clear_trk  = (complete && !in_range) || accept;

    sseg_digit_tracker #(.STABLE_COUNT(STABLE_COUNT)) u_ones (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_trk),
        .update   (upd_ones),
        .legal    (legal),
        .pattern  (bus.seg_in),
        .bcd_in   (bcd),
        .lock_upd (ones_lock),
        .bcd_upd  (ones_bcd)
    );

    sseg_digit_tracker #(.STABLE_COUNT(STABLE_COUNT)) u_tens (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_trk),
        .update   (upd_tens),
        .legal    (legal),
        .pattern  (bus.seg_in),
        .bcd_in   (bcd),
        .lock_upd (tens_lock),
        .bcd_upd  (tens_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_COLLECT;
            data_out_q    <= 6'd0;
            data_valid_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            // An illegal strobe clears a tracker, so it can never also
            // complete a value: the two error pulses are exclusive.
            pattern_err_q <= upd_ones || upd_tens ? !legal : 1'b0;
            range_err_q   <= complete && !in_range;
            case (state)
                ST_COLLECT: begin
                    if (complete && in_range) begin
                        data_out_q   <= value[5:0];
                        data_valid_q <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        data_valid_q <= 1'b0;
                        state        <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.range_err   = range_err_q;

endmodule

// File: tb/tb_sseg_reader.sv
// Directed bench for sseg_reader: a STABLE_COUNT=4 instance for the main
// scenarios and a STABLE_COUNT=1 instance for single-strobe locking.
// Inputs change on the falling edge; outputs are checked on the falling edge.
import sseg_pkg::*;

module tb_sseg_reader;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    sseg_reader_if bus ();
    sseg_reader_if bus1 ();

    sseg_reader #(.STABLE_COUNT(4), .MAX_VALUE(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sseg_reader #(.STABLE_COUNT(1), .MAX_VALUE(31)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe on the main bus; returns on the falling edge after the
    // capturing rising edge, so registered responses are visible on return.
    task automatic strobe(input logic sel, input logic [6:0] pat);
        @(negedge clk);
        bus.digit_sel  = sel;
        bus.seg_in     = pat;
        bus.seg_strobe = 1'b1;
        @(negedge clk);
        bus.seg_strobe = 1'b0;
        bus.seg_in     = SBLANK;
    endtask

    task automatic strobe_n(input logic sel, input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++)
            strobe(sel, pat);
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        check(tag, int'(bus.data_valid), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.seg_in      = SBLANK;
        bus.digit_sel   = 1'b0;
        bus.seg_strobe  = 1'b0;
        bus.data_ready  = 1'b0;
        bus1.seg_in     = SBLANK;
        bus1.digit_sel  = 1'b0;
        bus1.seg_strobe = 1'b0;
        bus1.data_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_out", int'(bus.data_out), 0);
        check("rst_perr", int'(bus.pattern_err), 0);
        check("rst_rerr", int'(bus.range_err), 0);

        // Ones locks first: 2 then tens 1 -> 12
        strobe_n(1'b0, S2, 4);
        strobe_n(1'b1, S1, 3);
        check("t12_early", int'(bus.data_valid), 0);
        strobe(1'b1, S1);
        check("t12_valid", int'(bus.data_valid), 1);
        check("t12_out", int'(bus.data_out), 12);
        take("t12_taken");

        // data_ready while idle is ignored, then interleaved 8/2 -> 28
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        check("idle_ready", int'(bus.data_valid), 0);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, S8);
            strobe(1'b1, S2);
        end
        strobe(1'b0, S8);
        check("t28_early", int'(bus.data_valid), 0);
        strobe(1'b1, S2);
        check("t28_valid", int'(bus.data_valid), 1);
        check("t28_out", int'(bus.data_out), 28);
        strobe_n(1'b0, S1, 4);
        strobe(1'b0, SBLANK);
        check("hold_perr", int'(bus.pattern_err), 0);
        check("hold_valid", int'(bus.data_valid), 1);
        check("hold_out", int'(bus.data_out), 28);
        take("t28_taken");

        // Glitch restart: tens 0 first, ones 5x3 then 6x4 -> 6
        strobe_n(1'b1, S0, 4);
        strobe_n(1'b0, S5, 3);
        check("glitch_5", int'(bus.data_valid), 0);
        strobe_n(1'b0, S6, 3);
        check("glitch_6x3", int'(bus.data_valid), 0);
        strobe(1'b0, S6);
        check("glitch_valid", int'(bus.data_valid), 1);
        check("glitch_out", int'(bus.data_out), 6);
        take("glitch_taken");

        // Illegal pattern: pulse, count restart, then 31 at the range limit
        strobe_n(1'b0, S1, 2);
        strobe(1'b0, SBLANK);
        check("perr_pulse", int'(bus.pattern_err), 1);
        check("perr_no_rerr", int'(bus.range_err), 0);
        @(negedge clk);
        check("perr_clear", int'(bus.pattern_err), 0);
        strobe_n(1'b0, S1, 3);
        strobe_n(1'b1, S3, 4);
        check("perr_restart", int'(bus.data_valid), 0);
        strobe(1'b0, S1);
        check("t31_valid", int'(bus.data_valid), 1);
        check("t31_out", int'(bus.data_out), 31);
        check("t31_rerr", int'(bus.range_err), 0);
        take("t31_taken");

        // Range error: 34 rejected, trackers cleared
        strobe_n(1'b1, S3, 4);
        strobe_n(1'b0, S4, 4);
        check("rerr_pulse", int'(bus.range_err), 1);
        check("rerr_valid", int'(bus.data_valid), 0);
        check("rerr_no_perr", int'(bus.pattern_err), 0);
        @(negedge clk);
        check("rerr_clear", int'(bus.range_err), 0);
        strobe(1'b0, S4);
        check("rerr_trk_clr", int'(bus.range_err), 0);
        strobe_n(1'b1, S1, 4);
        strobe_n(1'b0, S4, 2);
        check("t14_early", int'(bus.data_valid), 0);
        strobe(1'b0, S4);
        check("t14_valid", int'(bus.data_valid), 1);
        check("t14_out", int'(bus.data_out), 14);
        take("t14_taken");

        // Reset while holding 17
        strobe_n(1'b1, S1, 4);
        strobe_n(1'b0, S7, 4);
        check("t17_valid", int'(bus.data_valid), 1);
        check("t17_out", int'(bus.data_out), 17);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("hrst_valid", int'(bus.data_valid), 0);
        check("hrst_out", int'(bus.data_out), 0);
        strobe(1'b0, S7);
        strobe(1'b1, S1);
        check("hrst_trk_clr", int'(bus.data_valid), 0);
        strobe_n(1'b0, S7, 3);
        strobe_n(1'b1, S1, 2);
        check("hrst_early", int'(bus.data_valid), 0);
        strobe(1'b1, S1);
        check("hrst_valid2", int'(bus.data_valid), 1);
        check("hrst_out2", int'(bus.data_out), 17);
        take("hrst_taken");

        // STABLE_COUNT=1: one strobe per digit -> 19
        @(negedge clk);
        bus1.digit_sel  = 1'b0;
        bus1.seg_in     = S9;
        bus1.seg_strobe = 1'b1;
        @(negedge clk);
        check("sc1_early", int'(bus1.data_valid), 0);
        bus1.digit_sel  = 1'b1;
        bus1.seg_in     = S1;
        @(negedge clk);
        bus1.seg_strobe = 1'b0;
        check("sc1_valid", int'(bus1.data_valid), 1);
        check("sc1_out", int'(bus1.data_out), 19);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
